// File: rtl/seq_fsm_pkg.sv
// Shared encodings for the command sequencer: state codes, command codes,
// error causes and a legality helper for the state register.
package seq_fsm_pkg;

    localparam int STATE_W = 3;
    localparam int CMD_W   = 3;
    localparam int ERR_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DONE   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP    = 3'd0,
        CMD_START  = 3'd1,
        CMD_STEP   = 3'd2,
        CMD_BACK   = 3'd3,
        CMD_ABORT  = 3'd4,
        CMD_LOCK   = 3'd5,
        CMD_UNLOCK = 3'd6,
        CMD_RSVD   = 3'd7
    } cmd_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_ILLEGAL  = 2'd2,
        ERR_RSVD_CMD = 2'd3
    } err_e;

    // Codes 5..7 are not states; seeing one means the register was corrupted.
    function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
        return (s <= ST_ERROR);
    endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Dwell timer: counts cycles while enabled and flags expiry on the cycle
// that completes TIMEOUT enabled cycles, so the owner can react on that edge.
module seq_dwell_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; load restarts from zero, and the count saturates at expiry.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_count <= '0;
        end else if (enable && !expire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expire = enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/seq_fsm.sv
// Command-driven step sequencer: IDLE/RUN/DONE/LOCKED/ERROR with a step index,
// a RUN dwell timeout and a sticky error state that only reset clears.
module seq_fsm
    import seq_fsm_pkg::*;
#(
    parameter int NUM_STEPS = 4,
    parameter int TIMEOUT   = 255,
    parameter int OUT_W     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CMD_W-1:0]             cmd,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic [OUT_W-1:0]             out,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         done,
    output logic                         err,
    output logic [ERR_W-1:0]             err_code
);

    localparam int IDX_W = $clog2(NUM_STEPS);

    logic [STATE_W-1:0] r_state;
    logic [IDX_W-1:0]   r_step;
    logic [ERR_W-1:0]   r_err_code;

    logic [STATE_W-1:0] w_state_next;
    logic [IDX_W-1:0]   w_step_next;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_cmd_act;
    logic               w_illegal;
    logic               w_expire;
    logic               w_timer_load;
    logic               w_timer_en;

    // A real (non-NOP) command was taken this cycle; only these restart the dwell timer.
    assign w_cmd_act = cmd_valid && (r_state != ST_ERROR) && (cmd != CMD_NOP);

    // Corruption check: unencoded state or an index past the last step.
    assign w_illegal = (r_state != ST_ERROR) &&
                       (!is_legal_state(r_state) || (32'(r_step) >= NUM_STEPS));

    // Timer only runs in RUN; it is held cleared elsewhere so RUN entry starts at zero.
    assign w_timer_load = w_cmd_act || (r_state != ST_RUN);
    assign w_timer_en   = (r_state == ST_RUN);

    seq_dwell_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .load  (w_timer_load),
        .enable(w_timer_en),
        .expire(w_expire)
    );

    // State register: reset wins over any command presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_next;
            r_step     <= w_step_next;
            r_err_code <= w_err_next;
        end
    end

    // Next-state logic: corruption, then reserved command, then per-state commands;
    // in RUN an accepted command beats a same-cycle timeout.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_err_next   = r_err_code;
        if (w_illegal) begin
            w_state_next = ST_ERROR;
            w_err_next   = ERR_ILLEGAL;
        end else if (w_cmd_act && (cmd == CMD_RSVD)) begin
            w_state_next = ST_ERROR;
            w_err_next   = ERR_RSVD_CMD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_act && (cmd == CMD_START)) begin
                        w_state_next = ST_RUN;
                        w_step_next  = '0;
                    end else if (w_cmd_act && (cmd == CMD_LOCK)) begin
                        w_state_next = ST_LOCKED;
                    end
                end
                ST_RUN: begin
                    if (w_cmd_act && (cmd == CMD_STEP)) begin
                        if (r_step == IDX_W'(NUM_STEPS - 1)) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_step_next = r_step + IDX_W'(1);
                        end
                    end else if (w_cmd_act && (cmd == CMD_BACK)) begin
                        if (r_step == '0) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_step_next = r_step - IDX_W'(1);
                        end
                    end else if (w_cmd_act && (cmd == CMD_ABORT)) begin
                        w_state_next = ST_IDLE;
                        w_step_next  = '0;
                    end else if (!w_cmd_act && w_expire) begin
                        w_state_next = ST_ERROR;
                        w_err_next   = ERR_TIMEOUT;
                    end
                end
                ST_DONE: begin
                    if (w_cmd_act && (cmd == CMD_START)) begin
                        w_state_next = ST_RUN;
                        w_step_next  = '0;
                    end else if (w_cmd_act && (cmd == CMD_LOCK)) begin
                        w_state_next = ST_LOCKED;
                    end else if (w_cmd_act && (cmd == CMD_ABORT)) begin
                        w_state_next = ST_IDLE;
                        w_step_next  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_cmd_act && (cmd == CMD_UNLOCK)) begin
                        w_state_next = ST_IDLE;
                        w_step_next  = '0;
                    end
                end
                ST_ERROR: begin
                    w_state_next = ST_ERROR;
                end
                default: begin
                    w_state_next = ST_ERROR;
                    w_err_next   = ERR_ILLEGAL;
                end
            endcase
        end
    end

    // Outputs decode the registered state only, never the incoming command.
    always_comb begin
        out       = OUT_W'(r_state);
        step_idx  = r_step;
        done      = (r_state == ST_DONE);
        err       = (r_state == ST_ERROR);
        err_code  = r_err_code;
        cmd_ready = (r_state != ST_ERROR);
    end

endmodule

// File: tb/tb_seq_fsm.sv
// Bench for seq_fsm: directed scenarios plus random commands against a
// plain-integer reference model of the sequencer rules.
module tb_seq_fsm;

    localparam int NS = 4;
    localparam int TO = 255;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    cmd = 3'd0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [OW-1:0] out;
    logic [1:0]    step_idx;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    seq_fsm #(
        .NUM_STEPS(NS),
        .TIMEOUT  (TO),
        .OUT_W    (OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .out      (out),
        .step_idx (step_idx),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_txn   = 0;

    // Reference model: state as spec code, step index, error cause, cycles spent in RUN.
    int m_state = 0;
    int m_step  = 0;
    int m_code  = 0;
    int m_dwell = 0;

    // Command mix biased toward STEP so random runs reach DONE.
    int pick [10] = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 2};

    task automatic check_val(input string tag, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input int c, input bit v);
        bit act;
        act = v && (m_state != 4) && (c != 0);
        if (r) begin
            m_state = 0; m_step = 0; m_code = 0; m_dwell = 0;
        end else if (m_state == 4) begin
            // sticky until reset
        end else if (m_state > 4 || m_step >= NS) begin
            m_state = 4; m_code = 2;
        end else if (act && c == 7) begin
            m_state = 4; m_code = 3;
        end else if (!act) begin
            if (m_state == 1) begin
                m_dwell++;
                if (m_dwell >= TO) begin
                    m_state = 4; m_code = 1;
                end
            end
        end else begin
            if (m_state == 1) m_dwell = 0;
            if (m_state == 0) begin
                if (c == 1) begin m_state = 1; m_step = 0; m_dwell = 0; end
                else if (c == 5) m_state = 3;
            end else if (m_state == 1) begin
                if (c == 2) begin
                    if (m_step == NS - 1) m_state = 2;
                    else m_step++;
                end else if (c == 3) begin
                    if (m_step == 0) m_state = 0;
                    else m_step--;
                end else if (c == 4) begin
                    m_state = 0; m_step = 0;
                end
            end else if (m_state == 2) begin
                if (c == 1) begin m_state = 1; m_step = 0; m_dwell = 0; end
                else if (c == 5) m_state = 3;
                else if (c == 4) begin m_state = 0; m_step = 0; end
            end else if (m_state == 3) begin
                if (c == 6) begin m_state = 0; m_step = 0; end
            end
        end
    endtask

    // One clock transaction: drive, advance model, sample 1 time unit after the edge, compare.
    task automatic cycle(input string tag, input bit r, input int c, input bit v);
        rst = r; cmd = 3'(c); cmd_valid = v;
        model_edge(r, c, v);
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d %s rst=%0b cmd=%0d valid=%0b -> out=%0d idx=%0d done=%0b err=%0b code=%0d rdy=%0b",
                 n_txn, tag, r, c, v, out, step_idx, done, err, err_code, cmd_ready);
        check_val({tag, ".out"},  int'(out),       m_state);
        check_val({tag, ".idx"},  int'(step_idx),  m_step);
        check_val({tag, ".done"}, int'(done),      (m_state == 2) ? 1 : 0);
        check_val({tag, ".err"},  int'(err),       (m_state == 4) ? 1 : 0);
        check_val({tag, ".code"}, int'(err_code),  m_code);
        check_val({tag, ".rdy"},  int'(cmd_ready), (m_state == 4) ? 0 : 1);
        rst = 1'b0; cmd = 3'd0; cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cycle("reset", 1, 0, 0);
        check_val("reset_out", int'(out), 0);
        check_val("reset_rdy", int'(cmd_ready), 1);

        // START then STEP x3 walks 0..3, fourth STEP lands in DONE
        cycle("start", 0, 1, 1);
        check_val("walk_idx0", int'(step_idx), 0);
        for (int i = 1; i <= 3; i++) begin
            cycle("step", 0, 2, 1);
            check_val("walk_idx", int'(step_idx), i);
        end
        cycle("step_last", 0, 2, 1);
        check_val("walk_done_out", int'(out), 2);
        check_val("walk_done", int'(done), 1);
        cycle("abort_done", 0, 4, 1);

        // BACK at index 0 returns to IDLE
        cycle("start", 0, 1, 1);
        cycle("step", 0, 2, 1);
        cycle("back", 0, 3, 1);
        check_val("back_idx0", int'(step_idx), 0);
        cycle("back_zero", 0, 3, 1);
        check_val("back_idle", int'(out), 0);

        // LOCKED ignores ABORT and START, leaves on UNLOCK
        cycle("lock", 0, 5, 1);
        cycle("lk_abort", 0, 4, 1);
        cycle("lk_start", 0, 1, 1);
        check_val("lock_hold", int'(out), 3);
        cycle("unlock", 0, 6, 1);
        check_val("unlock_idle", int'(out), 0);

        // Command on the expiring cycle wins over the timeout
        cycle("start", 0, 1, 1);
        for (int i = 0; i < TO - 1; i++) cycle("idle_run", 0, 0, i[0]);
        cycle("step_at_expiry", 0, 2, 1);
        check_val("cmd_beats_timeout", int'(out), 1);

        // Full timeout, ERROR is sticky and refuses commands
        cycle("start", 0, 1, 1);
        for (int i = 0; i < TO - 1; i++) cycle("idle_run", 0, 0, 0);
        check_val("pre_timeout", int'(out), 1);
        cycle("expire", 0, 0, 0);
        check_val("timeout_out", int'(out), 4);
        check_val("timeout_code", int'(err_code), 1);
        cycle("err_start", 0, 1, 1);
        check_val("err_rdy", int'(cmd_ready), 0);
        cycle("err_rst", 1, 0, 0);
        check_val("err_cleared", int'(err), 0);

        // Corrupted state register is caught on the next edge
        @(negedge clk);
        force dut.r_state = 3'd7;
        #1;
        release dut.r_state;
        m_state = 7;
        #1;
        check_val("forced_out", int'(out), 7);
        cycle("illegal", 0, 0, 0);
        check_val("illegal_code", int'(err_code), 2);
        cycle("rst", 1, 0, 0);

        // Reserved command from IDLE
        cycle("rsvd", 0, 7, 1);
        check_val("rsvd_code", int'(err_code), 3);
        cycle("rst", 1, 0, 0);

        // Reset mid-RUN with STEP presented is discarded
        cycle("start", 0, 1, 1);
        cycle("step", 0, 2, 1);
        cycle("step", 0, 2, 1);
        cycle("rst_step", 1, 2, 1);
        check_val("rst_run_idx", int'(step_idx), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit v;
            int c;
            r = (m_state == 4) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 99) == 0) ? 7 : pick[$urandom_range(0, 9)];
            cycle("rand", r, c, v);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_fsm.md
SEQ_FSM -- requirements
Module: seq_fsm

Interface
REQ-001 Parameter NUM_STEPS, default 4, number of RUN steps (legal 2..16).
REQ-002 Parameter TIMEOUT, default 255, max cycles in one RUN step without a command (legal 1..65535).
REQ-003 Parameter OUT_W, default 3, width of out (legal >= 3).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cmd  input  3  command code: 0 NOP, 1 START, 2 STEP, 3 BACK, 4 ABORT, 5 LOCK, 6 UNLOCK, 7 reserved.
REQ-007 cmd_valid  input  1  cmd qualifier.
REQ-008 cmd_ready  output  1  command accepted this cycle when cmd_valid && cmd_ready.
REQ-009 out  output  OUT_W  registered state code, zero-extended.
REQ-010 step_idx  output  $clog2(NUM_STEPS)  current RUN step, 0-based, registered.
REQ-011 done  output  1  high while in DONE.
REQ-012 err  output  1  sticky error flag, high while in ERROR.
REQ-013 err_code  output  2  error cause: 0 none, 1 timeout, 2 illegal state, 3 reserved cmd.

Function
REQ-014 States and codes: IDLE=0, RUN=1, DONE=2, LOCKED=3, ERROR=4; out equals the current state code.
REQ-015 cmd_ready is 1 in every state except ERROR; a command in ERROR is ignored.
REQ-016 IDLE: START -> RUN with step_idx=0; LOCK -> LOCKED; other commands ignored.
REQ-017 RUN: STEP increments step_idx; STEP at step_idx=NUM_STEPS-1 -> DONE, step_idx held.
REQ-018 RUN: BACK decrements step_idx; BACK at step_idx=0 -> IDLE.
REQ-019 ABORT in RUN or DONE -> IDLE, step_idx=0, next cycle.
REQ-020 DONE: START -> RUN, step_idx=0; LOCK -> LOCKED; others ignored.
REQ-021 LOCKED: only UNLOCK accepted -> IDLE; all other commands, including ABORT, ignored.
REQ-022 Reserved cmd 7 accepted in any non-ERROR state -> ERROR, err_code=3.
REQ-023 Dwell counter resets on each accepted non-NOP command and on entry to RUN; reaching TIMEOUT cycles in RUN -> ERROR, err_code=1.
REQ-024 Unencoded state register value, or step_idx >= NUM_STEPS -> ERROR, err_code=2, on next edge; no state is unreachable from recovery.
REQ-025 ERROR exits only through rst; err and err_code hold until then.
REQ-026 Latency: accepted command changes out, step_idx and done on the following clock edge; outputs never depend combinationally on cmd.
REQ-027 cmd_valid low, or cmd=NOP: no state change, dwell counter keeps counting.
REQ-028 Same-cycle TIMEOUT expiry and accepted command: command wins, counter resets.

Reset
REQ-029 On rst high at clock edge: state IDLE, out=0, step_idx=0, done=0, err=0, err_code=0, dwell counter=0, cmd_ready=1.
REQ-030 rst asserted mid-RUN or in LOCKED/ERROR returns to IDLE on that edge; commands presented that cycle are discarded.

Structure
REQ-031 State codes, command codes and err_code values are defined in package seq_fsm_pkg.
REQ-032 The dwell timer is a sub-module seq_dwell_timer (load, enable, expire output), parametrised by TIMEOUT.
REQ-033 Sequential state and combinational next-state logic are separate blocks; every case statement has a default branch that routes to ERROR.

Verification
REQ-034 Reset, then START, STEP x3 (NUM_STEPS=4) -> step_idx 0,1,2,3; fourth STEP -> out=2, done=1.
REQ-035 START, STEP, BACK, BACK -> step_idx 1, 0, then out=0 (IDLE).
REQ-036 LOCK from IDLE, then ABORT and START -> out stays 3; UNLOCK -> out=0.
REQ-037 START, then no command for 255 cycles -> out=4, err=1, err_code=1; START ignored, cmd_ready=0; rst -> out=0, err=0.
REQ-038 Force state register to 7 -> next cycle out=4, err_code=2; cmd 7 from IDLE -> out=4, err_code=3.
REQ-039 Assert rst during RUN at step_idx=2 with STEP valid -> out=0, step_idx=0 on that edge.
